// File: rtl/toy_bus_slv_ram_responder.sv
// Toy bus target endpoint: strobed read/write on a 256-bit RAM, one in-order ack per request.
// Optional target-id check enabled by defining TOY_BUS_RSP_ID_CHK_EN.
module toy_bus_slv_ram_responder #(
    parameter logic [3:0]  NODE_ID   = 4'h2,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned DEPTH     = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_vld,
    output logic         req_rdy,
    input  logic [31:0]  req_addr,
    input  logic [255:0] req_data,
    input  logic [31:0]  req_strb,
    input  logic         req_opcode,
    input  logic [3:0]   req_src_id,
    input  logic [3:0]   req_tgt_id,
    input  logic [9:0]   req_sideband,
    output logic         ack_vld,
    input  logic         ack_rdy,
    output logic         ack_opcode,
    output logic [255:0] ack_data,
    output logic [9:0]   ack_sideband,
    output logic [3:0]   ack_src_id,
    output logic [3:0]   ack_tgt_id
);
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned DATA_W = 256;
    localparam int unsigned STRB_W = 32;
    localparam int unsigned SB_W   = 10;
    localparam int unsigned ID_W   = 4;
    localparam logic [31:0] SPAN   = 32'(DEPTH * 32);

    typedef struct packed {
        logic              opcode;
        logic [DATA_W-1:0] data;
        logic [SB_W-1:0]   sideband;
        logic [ID_W-1:0]   src_id;
        logic [ID_W-1:0]   tgt_id;
    } ack_t;

    logic [DATA_W-1:0] mem [DEPTH];

    logic             accept;
    logic             pop;
    logic [31:0]      offset;
    logic [IDX_W-1:0] idx;
    logic             id_ok;
    logic             access_ok;
    ack_t             push_ent;

    ack_t       head, head_nxt;
    ack_t       tail, tail_nxt;
    logic [1:0] count, count_nxt;

    assign accept    = req_vld & req_rdy;
    assign pop       = ack_vld & ack_rdy;
    assign offset    = req_addr - BASE_ADDR;
    assign idx       = offset[5 +: IDX_W];

`ifdef TOY_BUS_RSP_ID_CHK_EN
    assign id_ok     = (req_tgt_id == NODE_ID);
`else
    assign id_ok     = 1'b1;
`endif

    assign access_ok = (offset < SPAN) & id_ok;

    // Ack entry formed at the handshake; reads see all earlier writes
    always_comb begin
        push_ent          = '0;
        push_ent.opcode   = ~access_ok;
        push_ent.data     = (access_ok & ~req_opcode) ? mem[idx] : '0;
        push_ent.sideband = req_sideband;
        push_ent.src_id   = NODE_ID;
        push_ent.tgt_id   = req_src_id;
    end

    // RAM is not reset; only strobed bytes of an accepted in-range write change
    always_ff @(posedge clk) begin
        if (accept & access_ok & req_opcode) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (req_strb[b]) begin
                    mem[idx][b*8 +: 8] <= req_data[b*8 +: 8];
                end
            end
        end
    end

    // Two-entry ack FIFO: head drives the ack outputs directly
    always_comb begin
        head_nxt  = head;
        tail_nxt  = tail;
        count_nxt = count;
        unique case ({accept, pop})
            2'b10: begin
                if (count == 2'd0) begin
                    head_nxt = push_ent;
                end else begin
                    tail_nxt = push_ent;
                end
                count_nxt = count + 2'd1;
            end
            2'b01: begin
                head_nxt  = tail;
                count_nxt = count - 2'd1;
            end
            2'b11: begin
                if (count == 2'd1) begin
                    head_nxt = push_ent;
                end else begin
                    head_nxt = tail;
                    tail_nxt = push_ent;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head    <= '0;
            tail    <= '0;
            count   <= 2'd0;
            ack_vld <= 1'b0;
            req_rdy <= 1'b0;
        end else begin
            head    <= head_nxt;
            tail    <= tail_nxt;
            count   <= count_nxt;
            ack_vld <= (count_nxt != 2'd0);
            req_rdy <= (count_nxt < 2'd2);
        end
    end

    assign ack_opcode   = head.opcode;
    assign ack_data     = head.data;
    assign ack_sideband = head.sideband;
    assign ack_src_id   = head.src_id;
    assign ack_tgt_id   = head.tgt_id;

endmodule

// File: tb/tb_toy_bus_slv_ram_responder.sv
// Directed bench for toy_bus_slv_ram_responder.
module tb_toy_bus_slv_ram_responder;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_vld;
    logic         req_rdy;
    logic [31:0]  req_addr;
    logic [255:0] req_data;
    logic [31:0]  req_strb;
    logic         req_opcode;
    logic [3:0]   req_src_id;
    logic [3:0]   req_tgt_id;
    logic [9:0]   req_sideband;
    logic         ack_vld;
    logic         ack_rdy;
    logic         ack_opcode;
    logic [255:0] ack_data;
    logic [9:0]   ack_sideband;
    logic [3:0]   ack_src_id;
    logic [3:0]   ack_tgt_id;

    int passed = 0;
    int total  = 0;

    toy_bus_slv_ram_responder dut (
        .clk(clk), .rst_n(rst_n),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_addr(req_addr), .req_data(req_data),
        .req_strb(req_strb), .req_opcode(req_opcode), .req_src_id(req_src_id),
        .req_tgt_id(req_tgt_id), .req_sideband(req_sideband),
        .ack_vld(ack_vld), .ack_rdy(ack_rdy), .ack_opcode(ack_opcode), .ack_data(ack_data),
        .ack_sideband(ack_sideband), .ack_src_id(ack_src_id), .ack_tgt_id(ack_tgt_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_ack(input string tag, input logic op, input logic [255:0] d,
                           input logic [9:0] sb, input logic [3:0] tgt);
        chk({tag, "_vld"}, 256'(ack_vld), 256'(1'b1));
        chk({tag, "_op"},  256'(ack_opcode), 256'(op));
        chk({tag, "_data"}, ack_data, d);
        chk({tag, "_sb"},  256'(ack_sideband), 256'(sb));
        chk({tag, "_tgt"}, 256'(ack_tgt_id), 256'(tgt));
        chk({tag, "_src"}, 256'(ack_src_id), 256'(4'h2));
    endtask

    task automatic set_req(input logic [31:0] a, input logic [255:0] d, input logic [31:0] s,
                           input logic op, input logic [3:0] tgt, input logic [9:0] sb);
        req_addr = a; req_data = d; req_strb = s; req_opcode = op;
        req_src_id = 4'h5; req_tgt_id = tgt; req_sideband = sb;
    endtask

    // Present a request and hold it until accepted; returns #1 after the accepting edge
    task automatic send(input string tag, input logic [31:0] a, input logic [255:0] d,
                        input logic [31:0] s, input logic op, input logic [3:0] tgt,
                        input logic [9:0] sb);
        logic done;
        done = 1'b0;
        set_req(a, d, s, op, tgt, sb);
        req_vld = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            done = req_rdy;
            @(posedge clk); #1;
        end
        req_vld = 1'b0;
        chk({tag, "_accept"}, 256'(done), 256'(1'b1));
    endtask

    logic [255:0] d1, d2, ones, exp_d [4];
    logic [31:0]  addr_q [4];
    logic [255:0] held;
    int sent, got, stale;

    initial begin
        d1   = {8{32'hA5C3_0F10}} ^ {32'h0, 224'h1234_5678_9ABC};
        d2   = {8{32'h0BAD_F00D}};
        ones = '1;
        rst_n = 1'b0; req_vld = 1'b0; ack_rdy = 1'b0;
        set_req(32'h0, '0, '0, 1'b0, 4'h2, 10'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_rdy", 256'(req_rdy), 256'(1'b0));
        chk("rst_ack_vld", 256'(ack_vld), 256'(1'b0));
        chk("rst_ack_data", ack_data, '0);
        chk("rst_ack_sb", 256'(ack_sideband), 256'(10'h0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_rdy", 256'(req_rdy), 256'(1'b1));

        // T1 write then read, latency one
        ack_rdy = 1'b1;
        send("t1_wr", 32'h8000_0040, d1, 32'hFFFF_FFFF, 1'b1, 4'h2, 10'h3);
        chk_ack("t1_wr", 1'b0, '0, 10'h3, 4'h5);
        send("t1_rd", 32'h8000_0040, '0, '0, 1'b0, 4'h2, 10'h4);
        chk_ack("t1_rd", 1'b0, d1, 10'h4, 4'h5);
        send("t1_rd_lowbits", 32'h8000_005F, '0, '0, 1'b0, 4'h2, 10'h5);
        chk_ack("t1_rd_lowbits", 1'b0, d1, 10'h5, 4'h5);

        // T2 partial strobe, and zero-strobe write changes nothing
        send("t2_fill", 32'h8000_0100, ones, 32'hFFFF_FFFF, 1'b1, 4'h2, 10'h6);
        send("t2_part", 32'h8000_0100, '0, 32'h0000_000F, 1'b1, 4'h2, 10'h7);
        send("t2_zero", 32'h8000_0100, '0, 32'h0, 1'b1, 4'h2, 10'h8);
        chk_ack("t2_zero", 1'b0, '0, 10'h8, 4'h5);
        send("t2_rd", 32'h8000_0100, '0, '0, 1'b0, 4'h2, 10'h9);
        chk_ack("t2_rd", 1'b0, {224'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'h0},
                10'h9, 4'h5);
        @(posedge clk); #1;
        chk("t2_drained", 256'(ack_vld), 256'(1'b0));

        // T3 backpressure: two accepted, the rest wait, acks in order after release
        addr_q[0] = 32'h8000_0040; exp_d[0] = d1;
        addr_q[1] = 32'h8000_0100; exp_d[1] = {ones[255:32], 32'h0};
        addr_q[2] = 32'h8000_0040; exp_d[2] = d1;
        addr_q[3] = 32'h8000_0100; exp_d[3] = {ones[255:32], 32'h0};
        ack_rdy = 1'b0;
        send("t3_r0", addr_q[0], '0, '0, 1'b0, 4'h2, 10'd10);
        send("t3_r1", addr_q[1], '0, '0, 1'b0, 4'h2, 10'd11);
        set_req(addr_q[2], '0, '0, 1'b0, 4'h2, 10'd12);
        req_vld = 1'b1;
        held = ack_data;
        repeat (3) @(posedge clk);
        #1;
        chk("t3_full_rdy", 256'(req_rdy), 256'(1'b0));
        chk_ack("t3_hold", 1'b0, d1, 10'd10, 4'h5);
        chk("t3_hold_stable", ack_data, held);
        ack_rdy = 1'b1;
        sent = 2; got = 0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            logic take, seen;
            take = req_vld & req_rdy;
            seen = ack_vld;
            if (seen) begin
                chk($sformatf("t3_sb%0d", got), 256'(ack_sideband), 256'(10'(10 + got)));
                chk($sformatf("t3_data%0d", got), ack_data, exp_d[got]);
                got++;
            end
            @(posedge clk); #1;
            if (take) begin
                sent++;
                if (sent < 4) set_req(addr_q[sent], '0, '0, 1'b0, 4'h2, 10'(10 + sent));
                else req_vld = 1'b0;
            end
        end
        req_vld = 1'b0;
        chk("t3_all_acked", 256'(got), 256'(4));

        // T4 out of range reads and write, RAM untouched; last word in range
        send("t4_w0", 32'h8000_0000, d2, 32'hFFFF_FFFF, 1'b1, 4'h2, 10'h20);
        send("t4_lo", 32'h7FFF_FFE0, '0, '0, 1'b0, 4'h2, 10'h21);
        chk_ack("t4_lo", 1'b1, '0, 10'h21, 4'h5);
        send("t4_hi", 32'h8000_8000, '0, '0, 1'b0, 4'h2, 10'h22);
        chk_ack("t4_hi", 1'b1, '0, 10'h22, 4'h5);
        send("t4_hiwr", 32'h8000_8000, ones, 32'hFFFF_FFFF, 1'b1, 4'h2, 10'h23);
        chk_ack("t4_hiwr", 1'b1, '0, 10'h23, 4'h5);
        send("t4_rd0", 32'h8000_0000, '0, '0, 1'b0, 4'h2, 10'h24);
        chk_ack("t4_rd0", 1'b0, d2, 10'h24, 4'h5);
        send("t4_wlast", 32'h8000_7FE0, d1, 32'hFFFF_FFFF, 1'b1, 4'h2, 10'h25);
        send("t4_rlast", 32'h8000_7FE0, '0, '0, 1'b0, 4'h2, 10'h26);
        chk_ack("t4_rlast", 1'b0, d1, 10'h26, 4'h5);
        @(posedge clk); #1;

        // T5 reset with two requests outstanding
        ack_rdy = 1'b0;
        send("t5_r0", 32'h8000_0040, '0, '0, 1'b0, 4'h2, 10'h30);
        send("t5_r1", 32'h8000_0040, '0, '0, 1'b0, 4'h2, 10'h31);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_vld", 256'(ack_vld), 256'(1'b0));
        chk("t5_rst_rdy", 256'(req_rdy), 256'(1'b0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        ack_rdy = 1'b1;
        stale = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (ack_vld) stale++;
        end
        chk("t5_no_stale", 256'(stale), 256'(0));
        chk("t5_rdy_back", 256'(req_rdy), 256'(1'b1));

        // T6 target-id check
        send("t6_wa", 32'h8000_0200, d1, 32'hFFFF_FFFF, 1'b1, 4'h2, 10'h40);
        chk_ack("t6_wa", 1'b0, '0, 10'h40, 4'h5);
        send("t6_wb", 32'h8000_0200, d2, 32'hFFFF_FFFF, 1'b1, 4'h3, 10'h41);
`ifdef TOY_BUS_RSP_ID_CHK_EN
        chk_ack("t6_wb", 1'b1, '0, 10'h41, 4'h5);
        send("t6_rd", 32'h8000_0200, '0, '0, 1'b0, 4'h2, 10'h42);
        chk_ack("t6_rd", 1'b0, d1, 10'h42, 4'h5);
`else
        chk_ack("t6_wb", 1'b0, '0, 10'h41, 4'h5);
        send("t6_rd", 32'h8000_0200, '0, '0, 1'b0, 4'h2, 10'h42);
        chk_ack("t6_rd", 1'b0, d2, 10'h42, 4'h5);
`endif
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
